// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive FIFO
package uart_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t ASCII_CR          = 8'h0D;
  localparam int    RXF_DEPTH_DEFAULT = 16;

endpackage

// File: rtl/rxf_ptr.sv
// rtl/rxf_ptr.sv - wrap-bit pointer counter used for FIFO read and write sides
module rxf_ptr #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          i_inc,
  output logic [AW-1:0] o_idx,
  output logic          o_wrap
);

  logic [AW:0] r_ptr;

  // Advance by one on increment; the MSB toggles each time the index wraps to 0.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  assign o_idx  = r_ptr[AW-1:0];
  assign o_wrap = r_ptr[AW];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - non-throttling UART receive FIFO, FWFT output; optional CR line detect via UART_RX_FIFO_LINE_EN
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = RXF_DEPTH_DEFAULT,
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  input  logic             clr_ovf,
  output logic             line_avail
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    w_wr_idx;
  logic             w_wr_wrap;
  logic [PW-1:0]    w_rd_idx;
  logic             w_rd_wrap;
  logic [PW-1:0]    w_rd_idx_nxt;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_overrun;
  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] w_count_after_pop;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_m_tdata;
  logic             r_m_tvalid;
  logic             r_overflow;

  rxf_ptr #(.AW(PW)) u_wr_ptr (
    .clk    (clk),
    .nrst   (nrst),
    .i_inc  (w_push),
    .o_idx  (w_wr_idx),
    .o_wrap (w_wr_wrap)
  );

  rxf_ptr #(.AW(PW)) u_rd_ptr (
    .clk    (clk),
    .nrst   (nrst),
    .i_inc  (w_pop),
    .o_idx  (w_rd_idx),
    .o_wrap (w_rd_wrap)
  );

  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign w_full            = (w_wr_idx == w_rd_idx) && (w_wr_wrap != w_rd_wrap);
  assign w_pop             = r_m_tvalid & m_tready;
  assign w_push            = s_tvalid & (~w_full | w_pop);
  assign w_overrun         = s_tvalid & w_full & ~w_pop;
  assign w_rd_idx_nxt      = w_rd_idx + PW'(w_pop);
  assign w_count_after_pop = r_count - CNT_W'(w_pop);
  assign w_count_nxt       = w_count_after_pop + CNT_W'(w_push);

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_wr_idx] <= s_tdata;
    end
  end

  // Occupancy, registered head byte and sticky overrun (set beats clear).
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_count    <= '0;
      r_m_tdata  <= '0;
      r_m_tvalid <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_m_tvalid <= (w_count_nxt != '0);
      r_overflow <= w_overrun | (r_overflow & ~clr_ovf);
      if (w_push && (w_count_after_pop == '0)) begin
        r_m_tdata <= s_tdata;
      end else if (w_count_nxt != '0) begin
        r_m_tdata <= r_mem[w_rd_idx_nxt];
      end
    end
  end

  assign s_tready = 1'b1;
  assign m_tdata  = r_m_tdata;
  assign m_tvalid = r_m_tvalid;
  assign count    = r_count;
  assign overflow = r_overflow;

`ifdef UART_RX_FIFO_LINE_EN
  localparam logic [WIDTH-1:0] LP_CR = WIDTH'(ASCII_CR);

  logic [CNT_W-1:0] r_cr_cnt;
  logic [CNT_W-1:0] w_cr_cnt_nxt;
  logic             r_line_avail;

  assign w_cr_cnt_nxt = r_cr_cnt
                      + CNT_W'(w_push && (s_tdata == LP_CR))
                      - CNT_W'(w_pop && (r_m_tdata == LP_CR));

  // Count stored CR bytes so the consumer can wait for a whole command line.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cr_cnt     <= '0;
      r_line_avail <= 1'b0;
    end else begin
      r_cr_cnt     <= w_cr_cnt_nxt;
      r_line_avail <= (w_cr_cnt_nxt != '0);
    end
  end

  assign line_avail = r_line_avail;
`else
  assign line_avail = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo with queue reference model
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef UART_RX_FIFO_LINE_EN
  localparam bit LINE_ON = 1'b1;
`else
  localparam bit LINE_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic [WIDTH-1:0] s_tdata = '0;
  logic             s_tvalid = 1'b0;
  logic             s_tready;
  logic [WIDTH-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tready = 1'b0;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             clr_ovf = 1'b0;
  logic             line_avail;

  uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .count      (count),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf),
    .line_avail (line_avail)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass   = 0;
  bit    mon_en   = 1'b0;
  byte_t mq[$];
  byte_t exp_q[$];
  bit    m_ovf = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, expv, expv, $time);
  endtask

  function automatic int model_crs();
    int n = 0;
    foreach (mq[i]) if (mq[i] == ASCII_CR) n++;
    return n;
  endfunction

  function automatic int model_line();
    return (LINE_ON && (model_crs() != 0)) ? 1 : 0;
  endfunction

  // One clock of stimulus; the model advances at the same edge as the DUT.
  task automatic cycle(input logic sv, input byte_t sd, input logic rdy, input logic clr);
    bit mpop, mpush, movr;
    s_tvalid = sv;
    s_tdata  = sd;
    m_tready = rdy;
    clr_ovf  = clr;
    mpop  = (mq.size() > 0) && rdy;
    mpush = sv && ((mq.size() < DEPTH) || mpop);
    movr  = sv && !mpush;
    @(posedge clk);
    if (mpop) void'(mq.pop_front());
    if (mpush) begin
      mq.push_back(sd);
      exp_q.push_back(sd);
    end
    m_ovf = movr | (m_ovf & ~clr);
    #1;
  endtask

  // Monitor: checks every handshake and status against the model, away from the edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", int'(count), mq.size());
      chk("m_tvalid", int'(m_tvalid), (mq.size() != 0) ? 1 : 0);
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("line_avail", int'(line_avail), model_line());
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", 1, 0);
        end else begin
          chk("m_tdata", int'(m_tdata), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    byte_t pat;
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b1;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_m_tvalid", int'(m_tvalid), 0);
    chk("rst_m_tdata", int'(m_tdata), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_s_tready", int'(s_tready), 1);
    chk("rst_line_avail", int'(line_avail), 0);
    mon_en = 1'b1;
    cycle(0, 8'h00, 0, 0);

    // single byte in and out
    cycle(1, 8'h41, 0, 0);
    chk("single_tdata", int'(m_tdata), 8'h41);
    cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 0, 0);
    chk("single_empty", int'(m_tvalid), 0);

    // fill, then overrun with 0xAA
    for (int i = 0; i < DEPTH; i++) cycle(1, byte_t'(i), 0, 0);
    chk("fill_count", int'(count), DEPTH);
    cycle(1, 8'hAA, 0, 0);
    chk("ovr_flag", int'(overflow), 1);
    chk("ovr_count", int'(count), DEPTH);
    // clear and new overrun together: set wins
    cycle(1, 8'hAB, 0, 1);
    chk("ovr_set_wins", int'(overflow), 1);
    for (int i = 0; i < DEPTH; i++) cycle(0, 8'h00, 1, 0);
    chk("drain_empty", int'(m_tvalid), 0);
    cycle(0, 8'h00, 0, 1);
    chk("clr_ovf", int'(overflow), 0);

    // full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) cycle(1, byte_t'(8'h20 + i), 0, 0);
    cycle(1, 8'h55, 1, 0);
    chk("fullpp_count", int'(count), DEPTH);
    chk("fullpp_ovf", int'(overflow), 0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 8'h00, 1, 0);
    chk("fullpp_empty", int'(count), 0);

    // wrap-around traffic with random consumer duty
    pat = 8'h60;
    for (int i = 0; i < 40; i++) begin
      cycle(1, pat, 1'($urandom_range(0, 1)), 0);
      pat = pat + 8'h01;
      cycle(0, 8'h00, 1'($urandom_range(0, 1)), 0);
    end
    for (int i = 0; i < 2 * DEPTH; i++) cycle(0, 8'h00, 1, 0);

    // fully random phase
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), byte_t'($urandom_range(0, 3) == 0 ? ASCII_CR : $urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 2 * DEPTH; i++) cycle(0, 8'h00, 1, 1);

    // command line detection
    cycle(1, 8'h41, 0, 0);
    cycle(1, 8'h42, 0, 0);
    chk("line_before_cr", int'(line_avail), 0);
    cycle(1, ASCII_CR, 0, 0);
    chk("line_after_cr", int'(line_avail), LINE_ON ? 1 : 0);
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 0);
    chk("line_after_pop", int'(line_avail), 0);
    cycle(0, 8'h00, 0, 0);

    mon_en = 1'b0;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
